// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions that retires results
// in program order and raises a one-cycle registered flush on a bad commit.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   alloc_*         - dispatch side: request, payload, ready, index of tail entry
//   wb_*            - execute writeback: entry index, value, mispredict, exception
//   commit_*        - retirement of the head entry (combinational)
//   flush           - registered pipeline flush, high for exactly one cycle
//   empty           - no occupied entries
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int PREG_W = 6,
   parameter int AREG_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_valid,
   input  logic [AREG_W-1:0]        alloc_areg,
   input  logic [PREG_W-1:0]        alloc_preg,
   input  logic [PREG_W-1:0]        alloc_old_preg,
   output logic                     alloc_ready,
   output logic [$clog2(DEPTH)-1:0] alloc_idx,
   input  logic                     wb_valid,
   input  logic [$clog2(DEPTH)-1:0] wb_idx,
   input  logic [31:0]              wb_val,
   input  logic                     wb_mispred,
   input  logic                     wb_exception,
   output logic                     commit_valid,
   output logic [AREG_W-1:0]        commit_areg,
   output logic [PREG_W-1:0]        commit_preg,
   output logic [PREG_W-1:0]        commit_old_preg,
   output logic [31:0]              commit_val,
   output logic                     flush,
   output logic                     empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             flush_q, flush_d;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [DEPTH-1:0] mispred_q, mispred_d;
   logic [DEPTH-1:0] exc_q, exc_d;

   logic [AREG_W-1:0] areg_q [DEPTH];
   logic [AREG_W-1:0] areg_d [DEPTH];
   logic [PREG_W-1:0] preg_q [DEPTH];
   logic [PREG_W-1:0] preg_d [DEPTH];
   logic [PREG_W-1:0] old_preg_q [DEPTH];
   logic [PREG_W-1:0] old_preg_d [DEPTH];
   logic [31:0]       val_q [DEPTH];
   logic [31:0]       val_d [DEPTH];

   logic do_alloc;
   logic do_wb;

   assign alloc_ready = (count_q != CNT_FULL) && !flush_q;
   assign alloc_idx   = tail_q;
   assign empty       = (count_q == '0);
   assign flush       = flush_q;

   // Commit looks only at registered done, so a writeback to the head
   // becomes visible to retirement one cycle later.
   assign commit_valid    = valid_q[head_q] && done_q[head_q] && !flush_q;
   assign commit_areg     = areg_q[head_q];
   assign commit_preg     = preg_q[head_q];
   assign commit_old_preg = old_preg_q[head_q];
   assign commit_val      = val_q[head_q];

   assign do_alloc = alloc_valid && alloc_ready;
   assign do_wb    = wb_valid && valid_q[wb_idx] && !flush_q;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      flush_d    = 1'b0;
      valid_d    = valid_q;
      done_d     = done_q;
      mispred_d  = mispred_q;
      exc_d      = exc_q;
      areg_d     = areg_q;
      preg_d     = preg_q;
      old_preg_d = old_preg_q;
      val_d      = val_q;

      if (flush_q) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         valid_d   = '0;
         done_d    = '0;
         mispred_d = '0;
         exc_d     = '0;
      end else begin
         if (do_wb) begin
            done_d[wb_idx]    = 1'b1;
            val_d[wb_idx]     = wb_val;
            mispred_d[wb_idx] = wb_mispred;
            exc_d[wb_idx]     = wb_exception;
         end

         if (commit_valid) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
            flush_d         = mispred_q[head_q] | exc_q[head_q];
         end

         // Head and tail can only coincide when empty (no commit) or
         // full (no alloc), so these two writes never collide.
         if (do_alloc) begin
            valid_d[tail_q]    = 1'b1;
            done_d[tail_q]     = 1'b0;
            mispred_d[tail_q]  = 1'b0;
            exc_d[tail_q]      = 1'b0;
            areg_d[tail_q]     = alloc_areg;
            preg_d[tail_q]     = alloc_preg;
            old_preg_d[tail_q] = alloc_old_preg;
            tail_d             = tail_q + IDX_W'(1);
         end

         unique case ({do_alloc, commit_valid})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         flush_q   <= 1'b0;
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
         exc_q     <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         flush_q   <= flush_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         mispred_q <= mispred_d;
         exc_q     <= exc_d;
      end
   end

   // Payload is qualified by the valid bits, so it carries no reset.
   always_ff @(posedge clk) begin
      areg_q     <= areg_d;
      preg_q     <= preg_d;
      old_preg_q <= old_preg_d;
      val_q      <= val_d;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic,
// all checked against an in-order queue model of the buffer.
module tb_reorder_buffer;

   localparam int DEPTH  = 16;
   localparam int PREG_W = 6;
   localparam int AREG_W = 5;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              alloc_valid = 1'b0;
   logic [AREG_W-1:0] alloc_areg = '0;
   logic [PREG_W-1:0] alloc_preg = '0;
   logic [PREG_W-1:0] alloc_old_preg = '0;
   logic              alloc_ready;
   logic [IDX_W-1:0]  alloc_idx;
   logic              wb_valid = 1'b0;
   logic [IDX_W-1:0]  wb_idx = '0;
   logic [31:0]       wb_val = '0;
   logic              wb_mispred = 1'b0;
   logic              wb_exception = 1'b0;
   logic              commit_valid;
   logic [AREG_W-1:0] commit_areg;
   logic [PREG_W-1:0] commit_preg;
   logic [PREG_W-1:0] commit_old_preg;
   logic [31:0]       commit_val;
   logic              flush;
   logic              empty;

   reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_areg(alloc_areg),
      .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
      .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
      .wb_mispred(wb_mispred), .wb_exception(wb_exception),
      .commit_valid(commit_valid), .commit_areg(commit_areg),
      .commit_preg(commit_preg), .commit_old_preg(commit_old_preg),
      .commit_val(commit_val), .flush(flush), .empty(empty)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int                idx;
      logic [AREG_W-1:0] areg;
      logic [PREG_W-1:0] preg;
      logic [PREG_W-1:0] old;
      logic [31:0]       val;
      bit                done;
      bit                bad;
   } ent_t;

   ent_t q[$];
   int   m_head = 0;
   bit   m_flush = 1'b0;
   int   n_commits = 0;
   int   n_flushes = 0;

   task automatic model_reset();
      q.delete();
      m_head  = 0;
      m_flush = 1'b0;
   endtask

   task automatic check_outs();
      bit exp_cv;
      exp_cv = !m_flush && q.size() > 0;
      if (exp_cv) exp_cv = q[0].done;
      chk("alloc_ready", alloc_ready, 32'(q.size() < DEPTH && !m_flush));
      chk("alloc_idx", alloc_idx, 32'((m_head + q.size()) % DEPTH));
      chk("empty", empty, 32'(q.size() == 0));
      chk("flush", flush, 32'(m_flush));
      chk("commit_valid", commit_valid, 32'(exp_cv));
      if (exp_cv && commit_valid) begin
         chk("commit_areg", commit_areg, q[0].areg);
         chk("commit_preg", commit_preg, q[0].preg);
         chk("commit_old_preg", commit_old_preg, q[0].old);
         chk("commit_val", commit_val, q[0].val);
      end
   endtask

   task automatic model_edge(input bit av, input logic [AREG_W-1:0] ar,
                             input logic [PREG_W-1:0] pr,
                             input logic [PREG_W-1:0] op, input bit wv,
                             input int wi, input logic [31:0] wval,
                             input bit wm, input bit we);
      bit ready, cv, nf;
      int tail;
      if (m_flush) begin
         model_reset();
         return;
      end
      ready = q.size() < DEPTH;
      tail  = (m_head + q.size()) % DEPTH;
      cv    = q.size() > 0;
      if (cv) cv = q[0].done;
      nf    = cv ? q[0].bad : 1'b0;
      if (wv) begin
         foreach (q[i]) begin
            if (q[i].idx == wi) begin
               q[i].done = 1'b1;
               q[i].val  = wval;
               q[i].bad  = wm | we;
            end
         end
      end
      if (cv) begin
         void'(q.pop_front());
         m_head = (m_head + 1) % DEPTH;
         n_commits++;
      end
      if (av && ready)
         q.push_back('{idx: tail, areg: ar, preg: pr, old: op,
                       val: 32'h0, done: 1'b0, bad: 1'b0});
      if (nf) n_flushes++;
      m_flush = nf;
   endtask

   task automatic step(input bit av, input logic [AREG_W-1:0] ar,
                       input logic [PREG_W-1:0] pr,
                       input logic [PREG_W-1:0] op, input bit wv,
                       input int wi, input logic [31:0] wval,
                       input bit wm, input bit we);
      alloc_valid    = av;
      alloc_areg     = ar;
      alloc_preg     = pr;
      alloc_old_preg = op;
      wb_valid       = wv;
      wb_idx         = IDX_W'(wi);
      wb_val         = wval;
      wb_mispred     = wm;
      wb_exception   = we;
      #2;
      check_outs();
      @(posedge clk);
      model_edge(av, ar, pr, op, wv, wi, wval, wm, we);
      #1;
   endtask

   task automatic idle();
      step(0, '0, '0, '0, 0, 0, 32'h0, 0, 0);
   endtask

   task automatic alloc(input int a);
      step(1, AREG_W'(a), PREG_W'(a + 32), PREG_W'(a + 8),
           0, 0, 32'h0, 0, 0);
   endtask

   task automatic wb(input int i, input logic [31:0] v, input bit m);
      step(0, '0, '0, '0, 1, i, v, m, 0);
   endtask

   // Reset is raised between clock edges; outputs must settle at once.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_flush", flush, 0);
      chk("rst_alloc_idx", alloc_idx, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Three allocations, then out-of-order writebacks.
      for (int i = 1; i <= 3; i++) alloc(i);
      chk("after3_empty", empty, 0);
      chk("after3_commit", commit_valid, 0);
      wb(2, 32'hA, 0);
      wb(0, 32'hB, 0);
      idle();
      idle();
      chk("idx1_blocks", commit_valid, 0);
      wb(1, 32'hC, 0);
      for (int i = 0; i < 4; i++) idle();
      chk("drained", empty, 1);

      // Fill to capacity, overflow attempt, then wrap of alloc_idx.
      do_reset();
      for (int i = 0; i < 17; i++) alloc(i);
      chk("full_ready", alloc_ready, 0);
      wb(0, 32'h55, 0);
      idle();
      chk("wrap_idx", alloc_idx, 0);
      alloc(20);
      for (int i = 1; i < DEPTH; i++) wb(i, 32'(i * 3), 0);
      wb(0, 32'h77, 0);
      for (int i = 0; i < DEPTH + 2; i++) idle();
      chk("drained2", empty, 1);

      // Mispredicted commit flushes younger entries.
      do_reset();
      for (int i = 0; i < 3; i++) alloc(i + 4);
      wb(0, 32'h1, 0);
      wb(1, 32'h2, 1);
      wb(2, 32'h3, 0);
      for (int i = 0; i < 4; i++) idle();
      chk("post_flush_empty", empty, 1);
      chk("post_flush_idx", alloc_idx, 0);

      // Same-cycle allocate and commit at count 4.
      do_reset();
      for (int i = 0; i < 4; i++) alloc(i);
      wb(0, 32'h99, 0);
      alloc(9);
      idle();

      // Reset with five entries outstanding.
      do_reset();
      for (int i = 0; i < 5; i++) alloc(i);
      wb(1, 32'h5, 0);
      do_reset();
      alloc(1);

      // Random traffic.
      for (int n = 0; n < 4000; n++) begin
         bit av, wv, wm, we;
         int wi;
         if ($urandom_range(599) == 0) do_reset();
         av = $urandom_range(9) < 6;
         wv = $urandom_range(1) == 1;
         wm = $urandom_range(29) == 0;
         we = $urandom_range(39) == 0;
         if (q.size() > 0 && $urandom_range(3) != 0)
            wi = q[$urandom_range(q.size() - 1)].idx;
         else
            wi = $urandom_range(DEPTH - 1);
         step(av, AREG_W'($urandom), PREG_W'($urandom), PREG_W'($urandom),
              wv, wi, $urandom, wm, we);
      end

      if (n_commits < 100) chk("commit_activity", 0, 1);
      if (n_flushes < 3) chk("flush_activity", 0, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-002 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-003 SHALL have parameter AREG_W, default 5, architectural register index width.
REQ-004 Ports (name  direction  width  meaning); timing and reset are fixed: one clock, reset asynchronous and active-high.
- clk  in  1  single clock, all state changes on its rising edge
- rst  in  1  asynchronous active-high reset
- alloc_valid  in  1  dispatch requests one entry
- alloc_areg  in  AREG_W  destination architectural register
- alloc_preg  in  PREG_W  newly mapped physical register
- alloc_old_preg  in  PREG_W  previous mapping, freed at commit
- alloc_ready  out  1  entry available this cycle
- alloc_idx  out  log2(DEPTH)  index given to the allocated entry (the tail)
- wb_valid  in  1  execute result valid
- wb_idx  in  log2(DEPTH)  entry index of result
- wb_val  in  32  result value
- wb_mispred  in  1  branch mispredicted
- wb_exception  in  1  exception raised
- commit_valid  out  1  head entry retires this cycle
- commit_areg  out  AREG_W  retiring architectural register
- commit_preg  out  PREG_W  retiring physical register
- commit_old_preg  out  PREG_W  physical register to free
- commit_val  out  32  retiring value
- flush  out  1  pipeline flush request, registered
- empty  out  1  no occupied entries

Function
REQ-005 Circular buffer; head, tail pointers plus count of width log2(DEPTH)+1; per-entry fields valid, done, mispred, exception, areg, preg, old_preg, val.
REQ-006 alloc_ready SHALL equal (count != DEPTH) and not flush; alloc_idx SHALL equal tail, combinationally.
REQ-007 alloc_valid && alloc_ready SHALL write the entry at tail with valid=1, done=0, mispred=0, exception=0; tail increments modulo DEPTH.
REQ-008 alloc_valid while alloc_ready=0 SHALL be ignored; no state change.
REQ-009 wb_valid SHALL set done=1 and record val, mispred, exception at wb_idx; wb_valid to an entry with valid=0 SHALL be ignored.
REQ-010 commit_valid SHALL be combinational: entry at head has valid && done and flush=0; commit_* fields come from that entry.
REQ-011 On commit, the head entry valid clears and head increments modulo DEPTH; at most one commit per cycle.
REQ-012 Writeback to the head entry SHALL NOT commit in the same cycle; earliest commit is the cycle after writeback, minimum latency one cycle.
REQ-013 Commit of an entry with mispred or exception set SHALL set flush=1 on the next cycle for exactly one cycle.
REQ-014 While flush=1: all valid bits clear, head=tail=0, count=0; alloc, writeback and commit SHALL be ignored that cycle.
REQ-015 Simultaneous allocate and commit SHALL leave count unchanged; simultaneous allocate and commit when full is impossible because alloc_ready=0 when full.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-017 empty SHALL equal (count==0).

Reset
REQ-018 rst assertion, including mid-operation, SHALL immediately clear:
- head, tail, count, all valid/done/mispred/exception bits, flush to 0
- therefore commit_valid=0, alloc_ready=1, empty=1
REQ-019 Payload fields (areg, preg, old_preg, val) need not reset.

Verification
REQ-020 Reset, then allocate 3 entries (areg 1,2,3) -> alloc_idx 0,1,2; count=3; empty=0; commit_valid=0.
REQ-021 Writeback to idx 2 then 0 (vals 0xA, 0xB) -> commit of idx0 val 0xB one cycle after its writeback; idx1 blocks; idx2 commits only after idx1 writeback.
REQ-022 Allocate 16 without commit -> alloc_ready=0; 17th alloc ignored; one commit frees a slot, and alloc_idx wraps to 0.
REQ-023 Entry idx1 written back with wb_mispred=1, idx2 done -> idx1 commits, flush=1 the next cycle, idx2 never commits, empty=1 after flush.
REQ-024 Assert rst with 5 entries outstanding -> all outputs return to reset values without waiting for a clock edge; the next allocation gets idx 0.
REQ-025 Same-cycle alloc and commit at count=4 -> count stays 4; head and tail each advance by 1.
